// File: rtl/bk_carry_pipe.sv
// Three-stage pipelined Brent-Kung valence-2 carry network. Carry-in is folded
// into bit 0, the up-sweep is registered in S2, the down-sweep is registered in S3.
module bk_carry_pipe #(
  parameter int unsigned N_BIT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_BIT-1:0] p_in,
  input  logic [N_BIT-1:0] g_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT:0]   carry,
  output logic [N_BIT-1:0] p_out
);

  localparam int unsigned LOG2_N = $clog2(N_BIT);
  localparam int unsigned IW     = (LOG2_N > 0) ? LOG2_N : 1;

  logic             r_v1, r_v2, r_v3;
  logic [N_BIT-1:0] r_p1, r_g1, r_pf2, r_g2, r_p2;
  logic             r_cin1, r_cin2;
  logic [N_BIT:0]   r_carry;
  logic [N_BIT-1:0] r_pout;

  logic             w_load1, w_load2, w_load3;
  logic [N_BIT-1:0] w_gu, w_pu, w_gd;

  // A stage loads when it is empty or its occupant moves on this cycle.
  assign w_load3  = !r_v3 || out_ready;
  assign w_load2  = !r_v2 || w_load3;
  assign w_load1  = !r_v1 || w_load2;
  assign in_ready = w_load1;

  // Up-sweep: node i at level k spans 2^k bits and pulls in its 2^(k-1) neighbour.
  always_comb begin
    w_gu = r_g1;
    w_pu = r_p1;
    for (int k = 1; k <= int'(LOG2_N); k++) begin
      for (int i = 0; i < int'(N_BIT); i++) begin
        if (((i + 1) % (1 << k)) == 0) begin
          w_gu[IW'(i)] = w_gu[IW'(i)] | (w_pu[IW'(i)] & w_gu[IW'(i - (1 << (k - 1)))]);
          w_pu[IW'(i)] = w_pu[IW'(i)] & w_pu[IW'(i - (1 << (k - 1)))];
        end
      end
    end
  end

  // Down-sweep: fill the midpoints from the completed prefix just below each group.
  always_comb begin
    w_gd = r_g2;
    for (int k = int'(LOG2_N) - 1; k >= 1; k--) begin
      for (int i = 0; i < int'(N_BIT); i++) begin
        if ((((i + 1) % (1 << k)) == (1 << (k - 1))) && (i >= (1 << k))) begin
          w_gd[IW'(i)] = w_gd[IW'(i)] | (r_p2[IW'(i)] & w_gd[IW'(i - (1 << (k - 1)))]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_p1    <= '0;
      r_g1    <= '0;
      r_cin1  <= 1'b0;
      r_pf2   <= '0;
      r_g2    <= '0;
      r_p2    <= '0;
      r_cin2  <= 1'b0;
      r_carry <= '0;
      r_pout  <= '0;
    end else begin
      if (w_load1) r_v1 <= in_valid;
      if (w_load2) r_v2 <= r_v1;
      if (w_load3) r_v3 <= r_v2;
      if (in_valid && w_load1) begin
        r_p1   <= p_in;
        r_g1   <= {g_in[N_BIT-1:1], g_in[0] | (p_in[0] & cin)};
        r_cin1 <= cin;
      end
      if (r_v1 && w_load2) begin
        r_pf2  <= r_p1;
        r_g2   <= w_gu;
        r_p2   <= w_pu;
        r_cin2 <= r_cin1;
      end
      if (r_v2 && w_load3) begin
        r_carry <= {w_gd, r_cin2};
        r_pout  <= r_pf2;
      end
    end
  end

  assign out_valid = r_v3;
  assign carry     = r_carry;
  assign p_out     = r_pout;

endmodule

// File: tb/tb_bk_carry_pipe.sv
// Directed-table and sequence checks for bk_carry_pipe, finished by a random
// stream compared in order against a + b + cin.
module tb_bk_carry_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] p_in;
  logic [31:0] g_in;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] carry;
  logic [31:0] p_out;

  int n_cmp = 0;
  int n_err = 0;

  bk_carry_pipe #(.N_BIT(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .p_in(p_in), .g_in(g_in), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .carry(carry), .p_out(p_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p;
    logic [31:0] g;
    logic        ci;
    logic [32:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] ref_carry(input logic [31:0] a, input logic [31:0] b,
                                            input logic ci);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} + 33'(ci);
    return {s[32], s[31:0] ^ a ^ b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bp_a[4];
  logic [31:0] bp_b[4];
  logic        bp_c[4];

  logic [32:0] exp_q[$];
  logic [31:0] expp_q[$];

  initial begin
    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_FFFF_FFFF};
    tbl[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 33'h0_0000_0002};
    tbl[2] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000};
    tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33'h0_0000_0000};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001};
    tbl[5] = '{32'h0000_FFFE, 32'h0000_0001, 1'b0, 33'h0_0001_FFFE};
    tbl[6] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF};
    tbl[7] = '{32'h0F0F_0F0F, 32'h1010_1010, 1'b0, 33'h0_2020_2020};
    tbl[8] = '{32'hFFFF_0000, 32'h0000_8000, 1'b0, 33'h1_FFFF_0000};

    bp_a[0] = 32'h1234_5678; bp_b[0] = 32'h1111_1111; bp_c[0] = 1'b0;
    bp_a[1] = 32'hFFFF_0001; bp_b[1] = 32'h0000_FFFF; bp_c[1] = 1'b1;
    bp_a[2] = 32'h8000_0000; bp_b[2] = 32'h8000_0000; bp_c[2] = 1'b1;
    bp_a[3] = 32'h0F0F_F0F0; bp_b[3] = 32'hF0F0_0F10; bp_c[3] = 1'b0;

    rst_n = 1'b0; in_valid = 1'b0; p_in = '0; g_in = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_carry",     64'(carry),     64'd0);
    chk("rst_p_out",     64'(p_out),     64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    begin
      logic seen;
      seen = 1'b0;
      repeat (5) begin tick(); seen = seen | out_valid; end
      chk("idle_no_output", 64'(seen), 64'd0);
    end

    // Table: one vector at a time, checking the 3-cycle latency and single-cycle pulse.
    for (int t = 0; t < 9; t++) begin
      in_valid = 1'b1; p_in = tbl[t].p; g_in = tbl[t].g; cin = tbl[t].ci;
      chk($sformatf("tbl%0d_in_ready", t), 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_lat1", t), 64'(out_valid), 64'd0);
      tick();
      chk($sformatf("tbl%0d_lat2", t), 64'(out_valid), 64'd0);
      tick();
      chk($sformatf("tbl%0d_valid", t), 64'(out_valid), 64'd1);
      chk($sformatf("tbl%0d_carry", t), 64'(carry), 64'(tbl[t].exp));
      chk($sformatf("tbl%0d_p_out", t), 64'(p_out), 64'(tbl[t].p));
      tick();
      chk($sformatf("tbl%0d_pulse", t), 64'(out_valid), 64'd0);
      chk($sformatf("tbl%0d_hold", t), 64'(carry), 64'(tbl[t].exp));
    end

    // Backpressure: three vectors fill the pipe, the fourth is refused.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      p_in = bp_a[k] ^ bp_b[k]; g_in = bp_a[k] & bp_b[k]; cin = bp_c[k];
      #3;
      chk($sformatf("bp_in_ready%0d", k), 64'(in_ready), (k < 3) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_stall_valid%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp_stall_carry%0d", k), 64'(carry),
          64'(ref_carry(bp_a[0], bp_b[0], bp_c[0])));
      chk($sformatf("bp_stall_ready%0d", k), 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    #3;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_out0", 64'(carry), 64'(ref_carry(bp_a[0], bp_b[0], bp_c[0])));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("bp_valid%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp_out%0d", k), 64'(carry), 64'(ref_carry(bp_a[k], bp_b[k], bp_c[k])));
      chk($sformatf("bp_pout%0d", k), 64'(p_out), 64'(bp_a[k] ^ bp_b[k]));
      tick();
    end
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Asynchronous reset with vectors in flight: none of them may ever emerge.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      p_in = bp_a[k] ^ bp_b[k]; g_in = bp_a[k] & bp_b[k]; cin = bp_c[k];
      tick();
    end
    in_valid = 1'b0;
    chk("mid_rst_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_carry", 64'(carry), 64'd0);
    chk("mid_rst_p_out", 64'(p_out), 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (8) begin tick(); seen = seen | out_valid; end
      chk("mid_rst_discarded", 64'(seen), 64'd0);
    end

    // Random stream with random stalls on both sides.
    begin
      int          sent, rcv, cyc;
      logic        pend;
      logic [31:0] ra, rb;
      logic        rc;
      logic [32:0] e;
      logic [31:0] ep;
      sent = 0; rcv = 0; cyc = 0; pend = 1'b0;
      ra = '0; rb = '0; rc = 1'b0;
      while ((sent < 10000 || exp_q.size() > 0) && cyc < 60000) begin
        if (!pend && sent < 10000) begin
          ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1));
          if ($urandom_range(7) == 0) rb = ~ra;
          pend = 1'b1;
        end
        in_valid  = pend && ($urandom_range(3) != 0);
        p_in      = ra ^ rb;
        g_in      = ra & rb;
        cin       = rc;
        out_ready = ($urandom_range(3) != 0);
        #4;
        if (in_valid && in_ready) begin
          exp_q.push_back(ref_carry(ra, rb, rc));
          expp_q.push_back(ra ^ rb);
          sent++;
          pend = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("rand_unexpected_output", 64'd1, 64'd0);
          end else begin
            e  = exp_q.pop_front();
            ep = expp_q.pop_front();
            chk("rand_carry", 64'(carry), 64'(e));
            chk("rand_p_out", 64'(p_out), 64'(ep));
          end
          rcv++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      in_valid = 1'b0;
      chk("rand_count_in",  64'(sent), 64'd10000);
      chk("rand_count_out", 64'(rcv),  64'd10000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
